conv_window_scheduler: RTL

Parametrised window/anchor scheduler for the float16 convolution path: generalises the single-window anchor stepper to padding, arbitrary stride, multi-input/multi-output channel iteration, a valid/ready request handshake and credit-limited result tracking. It sits between the layer top and the convolution compute unit (CU). It emits one request per (output channel, window, input channel) tuple, tags accumulator-clear and accumulator-last boundaries, and signals `done` once every issued window's result has returned.

---
 rtl/conv_window_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/conv_window_scheduler.sv
// Window/anchor scheduler for the float16 conv path: walks (out_ch, row, col, in_ch)
// tuples, hands them to the CU over valid/ready, and tracks returned window results.
module conv_window_scheduler #(
  parameter int anchor_width    = 16,
  parameter int input_channel   = 2,
  parameter int output_channel  = 1,
  parameter int image_length    = 4,
  parameter int image_width     = 4,
  parameter int weight_length   = 3,
  parameter int weight_width    = 3,
  parameter int stride          = 1,
  parameter int padding         = 0,
  parameter int max_outstanding = 2,
  localparam int IC_W = (input_channel  > 1) ? $clog2(input_channel)  : 1,
  localparam int OC_W = (output_channel > 1) ? $clog2(output_channel) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [anchor_width-1:0] anchor_1D_o,
  output logic [anchor_width-1:0] anchor_2D_o,
  output logic [anchor_width-1:0] out_col_o,
  output logic [anchor_width-1:0] out_row_o,
  output logic [IC_W-1:0]         in_ch_o,
  output logic [OC_W-1:0]         out_ch_o,
  output logic                    acc_first_o,
  output logic                    acc_last_o,
  input  logic                    cu_out_valid_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int L    = image_length + 2*padding - weight_length;
  localparam int W    = image_width  + 2*padding - weight_width;
  localparam int OS_W = $clog2(max_outstanding + 1);

  // Last anchor is the largest multiple of stride that still fits a full kernel.
  localparam logic [anchor_width-1:0] A1_LAST = anchor_width'((L / stride) * stride);
  localparam logic [anchor_width-1:0] A2_LAST = anchor_width'((W / stride) * stride);
  localparam logic [anchor_width-1:0] STEP    = anchor_width'(stride);
  localparam logic [IC_W-1:0]         IC_LAST = IC_W'(input_channel - 1);
  localparam logic [OC_W-1:0]         OC_LAST = OC_W'(output_channel - 1);
  localparam logic [OS_W-1:0]         OS_MAX  = OS_W'(max_outstanding);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [anchor_width-1:0] a1_q, a2_q, col_q, row_q;
  logic [anchor_width-1:0] a1_d, a2_d, col_d, row_d;
  logic [IC_W-1:0]         ic_q, ic_d;
  logic [OC_W-1:0]         oc_q, oc_d;
  logic [OS_W-1:0]         os_q;
  logic                    err_q;

  logic run, ic_end, a1_end, a2_end, oc_end, last_tuple, xfer, inc, dec;

  assign run        = (state_q == RUN);
  assign ic_end     = (ic_q == IC_LAST);
  assign a1_end     = (a1_q == A1_LAST);
  assign a2_end     = (a2_q == A2_LAST);
  assign oc_end     = (oc_q == OC_LAST);
  assign last_tuple = ic_end && a1_end && a2_end && oc_end;

  // Only a result-producing tuple needs a free credit; accumulate-only tuples never stall.
  assign req_valid_o = run && (!ic_end || (os_q < OS_MAX));
  assign xfer        = req_valid_o && req_ready_i;
  assign inc         = xfer && ic_end;
  assign dec         = cu_out_valid_i && (os_q != '0);

  assign anchor_1D_o = a1_q;
  assign anchor_2D_o = a2_q;
  assign out_col_o   = col_q;
  assign out_row_o   = row_q;
  assign in_ch_o     = ic_q;
  assign out_ch_o    = oc_q;
  assign acc_first_o = run && (ic_q == '0);
  assign acc_last_o  = run && ic_end;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

  // Odometer step; the final tuple wraps every index back to 0 for DRAIN/DONE.
  always_comb begin
    a1_d  = a1_q;
    a2_d  = a2_q;
    col_d = col_q;
    row_d = row_q;
    ic_d  = ic_q;
    oc_d  = oc_q;
    if (!ic_end) begin
      ic_d = ic_q + 1'b1;
    end else begin
      ic_d = '0;
      if (!a1_end) begin
        a1_d  = a1_q + STEP;
        col_d = col_q + 1'b1;
      end else begin
        a1_d  = '0;
        col_d = '0;
        if (!a2_end) begin
          a2_d  = a2_q + STEP;
          row_d = row_q + 1'b1;
        end else begin
          a2_d  = '0;
          row_d = '0;
          oc_d  = oc_end ? '0 : oc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      a1_q    <= '0;
      a2_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
      os_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10:   os_q <= os_q + 1'b1;
        2'b01:   os_q <= os_q - 1'b1;
        default: ;
      endcase
      if (cu_out_valid_i && (os_q == '0)) err_q <= 1'b1;
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          err_q   <= 1'b0;
        end
        RUN: if (xfer) begin
          a1_q  <= a1_d;
          a2_q  <= a2_d;
          col_q <= col_d;
          row_q <= row_d;
          ic_q  <= ic_d;
          oc_q  <= oc_d;
          if (last_tuple) state_q <= DRAIN;
        end
        DRAIN: if (os_q == '0) state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
